// File: rtl/rr_grant_sequencer_if.sv
// Request/grant bundle between the requesters and the round-robin grant sequencer.
// The sequencer uses the slave modport; requester-side logic uses master.
interface rr_grant_sequencer_if;
  logic [3:0] req;
  logic       done;
  logic [1:0] grant_idx;
  logic       grant_en;
  logic       timeout;
  logic [7:0] grant_cnt;

  modport master (
    output req, done,
    input  grant_idx, grant_en, timeout, grant_cnt
  );

  modport slave (
    input  req, done,
    output grant_idx, grant_en, timeout, grant_cnt
  );
endinterface

// File: rtl/rr_grant_sequencer.sv
// Four-way round-robin grant sequencer feeding a 2-to-4 decoder (select + enable).
// A grant is held until done, request drop or hold timeout, and is followed by a dead cycle.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no grant; arbitrate req circularly starting at ptr
// GRANT | grant_en high, grant_idx stable, watch release conditions
// GAP   | one dead cycle after a release, req not evaluated
module rr_grant_sequencer #(
  parameter int MAX_HOLD = 15
) (
  input logic              clk,
  input logic              rst,
  rr_grant_sequencer_if.slave bus
);

  localparam int HW = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [1:0]     ptr, ptr_nxt;
  logic [HW-1:0]  hold_cnt, hold_cnt_nxt;
  logic [1:0]     grant_idx, grant_idx_nxt;
  logic           timeout, timeout_nxt;
  logic [7:0]     grant_cnt, grant_cnt_nxt;

  logic [7:0]     req_dbl;
  logic [3:0]     req_rot;
  logic [1:0]     pick_ofs;
  logic [1:0]     pick_idx;

  // Rotating the doubled request vector puts requester ptr at bit 0,
  // so a fixed-priority pick on req_rot is a circular scan from ptr.
  assign req_dbl = {bus.req, bus.req};
  assign req_rot = req_dbl[ptr +: 4];

  always_comb begin
    pick_ofs = 2'd0;
    if (req_rot[0])      pick_ofs = 2'd0;
    else if (req_rot[1]) pick_ofs = 2'd1;
    else if (req_rot[2]) pick_ofs = 2'd2;
    else if (req_rot[3]) pick_ofs = 2'd3;
  end

  assign pick_idx = ptr + pick_ofs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      hold_cnt  <= '0;
      grant_idx <= 2'd0;
      timeout   <= 1'b0;
      grant_cnt <= 8'd0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      hold_cnt  <= hold_cnt_nxt;
      grant_idx <= grant_idx_nxt;
      timeout   <= timeout_nxt;
      grant_cnt <= grant_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    hold_cnt_nxt  = hold_cnt;
    grant_idx_nxt = grant_idx;
    timeout_nxt   = 1'b0;
    grant_cnt_nxt = grant_cnt;

    unique case (state)
      IDLE: begin
        if (bus.req != 4'b0000) begin
          grant_idx_nxt = pick_idx;
          hold_cnt_nxt  = '0;
          grant_cnt_nxt = grant_cnt + 8'd1;
          state_nxt     = GRANT;
        end
      end

      // done outranks a dropped request, which outranks the hold limit
      GRANT: begin
        if (bus.done || !bus.req[grant_idx]) begin
          ptr_nxt   = grant_idx + 2'd1;
          state_nxt = GAP;
        end else if (hold_cnt == HW'(MAX_HOLD - 1)) begin
          ptr_nxt     = grant_idx + 2'd1;
          timeout_nxt = 1'b1;
          state_nxt   = GAP;
        end else begin
          hold_cnt_nxt = hold_cnt + HW'(1);
        end
      end

      GAP: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // grant_en comes straight from the state register so reset kills it at once
  assign bus.grant_en  = (state == GRANT);
  assign bus.grant_idx = grant_idx;
  assign bus.timeout   = timeout;
  assign bus.grant_cnt = grant_cnt;

endmodule

// File: tb/tb_rr_grant_sequencer.sv
// Directed bench for rr_grant_sequencer: round-robin order, release causes,
// dead-cycle spacing, async reset, grant counter wrap and MAX_HOLD=1.
module tb_rr_grant_sequencer;

  logic clk;
  logic rst;
  int   n_asserts;
  int   n_fail;

  rr_grant_sequencer_if bus ();
  rr_grant_sequencer_if bus1 ();

  rr_grant_sequencer #(.MAX_HOLD(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  rr_grant_sequencer #(.MAX_HOLD(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] dec_out;
  assign dec_out = bus.grant_en ? (4'b0001 << bus.grant_idx) : 4'b0000;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic release_done(input string tag);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    chk({tag, "_rel_en"}, {7'd0, bus.grant_en}, 8'd0);
    chk({tag, "_rel_to"}, {7'd0, bus.timeout}, 8'd0);
  endtask

  initial begin
    n_asserts = 0;
    n_fail    = 0;
    rst       = 1'b1;
    bus.req   = 4'b0000;
    bus.done  = 1'b0;
    bus1.req  = 4'b0000;
    bus1.done = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_en",  {7'd0, bus.grant_en}, 8'd0);
    chk("rst_to",  {7'd0, bus.timeout},  8'd0);
    chk("rst_cnt", bus.grant_cnt,        8'd0);
    chk("rst_idx", {6'd0, bus.grant_idx}, 8'd0);
    rst = 1'b0;

    // single requester 2
    bus.req = 4'b0100;
    tick();
    chk("t1_en",  {7'd0, bus.grant_en},  8'd1);
    chk("t1_idx", {6'd0, bus.grant_idx}, 8'd2);
    chk("t1_cnt", bus.grant_cnt,         8'd1);
    chk("t1_dec", {4'd0, dec_out},       8'h04);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    bus.req  = 4'b0000;
    chk("t1_rel_en", {7'd0, bus.grant_en}, 8'd0);
    chk("t1_rel_to", {7'd0, bus.timeout},  8'd0);
    chk("t1_dec0",   {4'd0, dec_out},      8'h00);
    tick();
    // ptr is 3 now, so 1001 must pick requester 3 rather than 0
    bus.req = 4'b1001;
    tick();
    chk("t1_ptr_idx", {6'd0, bus.grant_idx}, 8'd3);
    chk("t1_ptr_cnt", bus.grant_cnt,         8'd2);
    release_done("t1b");

    // all requesting: 0,1,2,3,0 with two low cycles between grants
    bus.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_gap_en", {7'd0, bus.grant_en}, 8'd0);
      tick();
      chk("t2_en",  {7'd0, bus.grant_en},  8'd1);
      chk("t2_idx", {6'd0, bus.grant_idx}, 8'((i % 4)));
      release_done("t2");
    end
    chk("t2_cnt", bus.grant_cnt, 8'd7);

    // hold timeout with a single requester
    bus.req = 4'b0001;
    tick();
    tick();
    chk("t3_en",  {7'd0, bus.grant_en},  8'd1);
    chk("t3_idx", {6'd0, bus.grant_idx}, 8'd0);
    for (int i = 1; i < 15; i++) begin
      tick();
      chk("t3_hold_en", {7'd0, bus.grant_en}, 8'd1);
      chk("t3_hold_to", {7'd0, bus.timeout},  8'd0);
    end
    tick();
    chk("t3_rel_en", {7'd0, bus.grant_en}, 8'd0);
    chk("t3_rel_to", {7'd0, bus.timeout},  8'd1);
    tick();
    chk("t3_to_low", {7'd0, bus.timeout},  8'd0);
    chk("t3_idle_en", {7'd0, bus.grant_en}, 8'd0);
    tick();
    chk("t3_regrant_en",  {7'd0, bus.grant_en},  8'd1);
    chk("t3_regrant_idx", {6'd0, bus.grant_idx}, 8'd0);
    chk("t3_cnt",         bus.grant_cnt,         8'd9);
    release_done("t3");

    // requester 1 drops its request mid-grant
    bus.req = 4'b0011;
    tick();
    tick();
    chk("t4_idx", {6'd0, bus.grant_idx}, 8'd1);
    bus.req = 4'b0001;
    tick();
    chk("t4_drop_en", {7'd0, bus.grant_en}, 8'd0);
    chk("t4_drop_to", {7'd0, bus.timeout},  8'd0);
    bus.req = 4'b0011;
    tick();
    tick();
    chk("t4_next_idx", {6'd0, bus.grant_idx}, 8'd0);
    chk("t4_cnt",      bus.grant_cnt,         8'd11);
    release_done("t4");

    // async reset in the middle of a grant to requester 3
    bus.req = 4'b1000;
    tick();
    tick();
    chk("t5_idx", {6'd0, bus.grant_idx}, 8'd3);
    chk("t5_en",  {7'd0, bus.grant_en},  8'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("t5_rst_en",  {7'd0, bus.grant_en},  8'd0);
    chk("t5_rst_to",  {7'd0, bus.timeout},   8'd0);
    chk("t5_rst_cnt", bus.grant_cnt,         8'd0);
    chk("t5_rst_idx", {6'd0, bus.grant_idx}, 8'd0);
    #1;
    rst = 1'b0;
    tick();
    chk("t5_after_idx", {6'd0, bus.grant_idx}, 8'd3);
    chk("t5_after_cnt", bus.grant_cnt,         8'd1);

    // drive the counter through 256 grants
    bus.req = 4'b1111;
    for (int k = 2; k <= 256; k++) begin
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0;
      tick();
      tick();
      chk("t6_en",  {7'd0, bus.grant_en},  8'd1);
      chk("t6_idx", {6'd0, bus.grant_idx}, 8'((k - 2) % 4));
    end
    chk("t6_wrap_cnt", bus.grant_cnt, 8'd0);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    bus.req  = 4'b0000;
    tick();
    bus.done = 1'b1;
    tick();
    chk("t6_idle_done_en",  {7'd0, bus.grant_en}, 8'd0);
    chk("t6_idle_done_cnt", bus.grant_cnt,        8'd0);
    chk("t6_idle_done_to",  {7'd0, bus.timeout},  8'd0);
    bus.req = 4'b0010;
    tick();
    chk("t6_grant_en",  {7'd0, bus.grant_en},  8'd1);
    chk("t6_grant_idx", {6'd0, bus.grant_idx}, 8'd1);
    chk("t6_grant_cnt", bus.grant_cnt,         8'd1);
    tick();
    bus.done = 1'b0;
    chk("t6_rel_en", {7'd0, bus.grant_en}, 8'd0);
    chk("t6_rel_to", {7'd0, bus.timeout},  8'd0);

    // MAX_HOLD=1: every grant is one cycle long and ends in a timeout
    bus1.req = 4'b0001;
    tick();
    chk("t7_en",    {7'd0, bus1.grant_en},  8'd1);
    chk("t7_idx",   {6'd0, bus1.grant_idx}, 8'd0);
    tick();
    chk("t7_rel_en", {7'd0, bus1.grant_en}, 8'd0);
    chk("t7_rel_to", {7'd0, bus1.timeout},  8'd1);
    tick();
    chk("t7_to_low", {7'd0, bus1.timeout},  8'd0);
    chk("t7_gap_en", {7'd0, bus1.grant_en}, 8'd0);
    tick();
    chk("t7_re_en",  {7'd0, bus1.grant_en}, 8'd1);
    chk("t7_cnt",    bus1.grant_cnt,        8'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
